// File: rtl/util_axis_uart_tx_if.sv
// AXI-stream byte channel between a byte producer and the UART serialiser.
// Handshake: a word moves on every aclk rising edge where tvalid and tready are both 1;
// the master holds tdata stable while tvalid=1 and tready=0, and the slave never looks
// at tdata unless tready=1.
interface util_axis_uart_tx_if #(
    parameter int DATA_BITS = 8
) ();
    logic [DATA_BITS-1:0] tdata;
    logic                 tvalid;
    logic                 tready;

    modport master (output tdata, output tvalid, input tready);
    modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/util_axis_uart_tx.sv
// AXI-stream to UART serialiser. A one-word holding register takes the next byte while
// the current frame shifts out; frames are start, data LSB first, optional parity, stop.
// All bit-timing transitions happen only on edges where the external baud strobe is high.
module util_axis_uart_tx #(
    parameter int parity_ena  = 1,
    parameter int parity_type = 1,
    parameter int stop_bits   = 1,
    parameter int data_bits   = 8
) (
    input  logic                     aclk,
    input  logic                     arstn,
    util_axis_uart_tx_if.slave       s_axis,
    input  logic                     uart_ena,
    output logic                     txd,
    output logic                     uart_busy,
    output logic [2:0]               dbg_state
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [data_bits-1:0] r_hold;
    logic [data_bits-1:0] r_shift;
    logic                 r_hold_valid;
    logic                 r_tready;
    logic                 r_txd;
    logic                 r_busy;
    logic                 r_parity;
    logic [2:0]           r_bit_cnt;
    logic                 r_stop_cnt;

    logic                 w_accept;
    logic                 w_load;
    logic                 w_last_data;
    logic                 w_last_stop;
    logic                 w_hold_valid_nxt;
    logic                 w_txd_nxt;
    logic                 w_parity;

    // tready mirrors "holding register empty", so accept and load can never coincide.
    assign w_accept         = s_axis.tvalid & r_tready;
    assign w_last_data      = (r_bit_cnt == 3'(data_bits - 1));
    assign w_last_stop      = (stop_bits == 1) | r_stop_cnt;
    assign w_load           = uart_ena & r_hold_valid &
                              ((r_state == ST_IDLE) | ((r_state == ST_STOP) & w_last_stop));
    assign w_hold_valid_nxt = w_accept | (r_hold_valid & ~w_load);
    assign w_parity         = (parity_type != 0) ? ~^r_hold : ^r_hold;

    assign s_axis.tready = r_tready;
    assign txd           = r_txd;
    assign uart_busy     = r_busy;
    assign dbg_state     = r_state;

    // FSM state register.
    always_ff @(posedge aclk or negedge arstn) begin
        if (!arstn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state; nothing moves except on a baud strobe.
    always_comb begin
        w_state_nxt = r_state;
        if (uart_ena) begin
            case (r_state)
                ST_IDLE:   if (r_hold_valid) w_state_nxt = ST_START;
                ST_START:  w_state_nxt = ST_DATA;
                ST_DATA:   if (w_last_data) w_state_nxt = (parity_ena != 0) ? ST_PARITY : ST_STOP;
                ST_PARITY: w_state_nxt = ST_STOP;
                ST_STOP:   if (w_last_stop) w_state_nxt = r_hold_valid ? ST_START : ST_IDLE;
                default:   w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // FSM output: the line level for the bit period that starts at this strobe.
    always_comb begin
        w_txd_nxt = r_txd;
        if (uart_ena) begin
            case (r_state)
                ST_IDLE:   w_txd_nxt = ~r_hold_valid;
                ST_START:  w_txd_nxt = r_shift[0];
                ST_DATA:   w_txd_nxt = w_last_data ? ((parity_ena != 0) ? r_parity : 1'b1)
                                                   : r_shift[1];
                ST_PARITY: w_txd_nxt = 1'b1;
                ST_STOP:   w_txd_nxt = ~(w_last_stop & r_hold_valid);
                default:   w_txd_nxt = 1'b1;
            endcase
        end
    end

    // Holding register and its AXIS handshake.
    always_ff @(posedge aclk or negedge arstn) begin
        if (!arstn) begin
            r_hold       <= '0;
            r_hold_valid <= 1'b0;
            r_tready     <= 1'b0;
        end else begin
            if (w_accept) begin
                r_hold <= s_axis.tdata;
            end
            r_hold_valid <= w_hold_valid_nxt;
            r_tready     <= ~w_hold_valid_nxt;
        end
    end

    // Shifter, parity and bit counters for the frame in flight.
    always_ff @(posedge aclk or negedge arstn) begin
        if (!arstn) begin
            r_shift    <= '0;
            r_parity   <= 1'b0;
            r_bit_cnt  <= '0;
            r_stop_cnt <= 1'b0;
        end else begin
            if (w_load) begin
                r_shift  <= r_hold;
                r_parity <= w_parity;
            end else if (uart_ena && (r_state == ST_DATA) && !w_last_data) begin
                r_shift <= r_shift >> 1;
            end
            if (uart_ena && (r_state == ST_START)) begin
                r_bit_cnt <= '0;
            end else if (uart_ena && (r_state == ST_DATA)) begin
                r_bit_cnt <= r_bit_cnt + 3'd1;
            end
            // Counter returns to 0 when the final stop period ends, ready for the next frame.
            if (uart_ena && (r_state == ST_STOP)) begin
                r_stop_cnt <= ~w_last_stop;
            end
        end
    end

    // Serial line and busy flag, both registered; line idles high out of reset.
    always_ff @(posedge aclk or negedge arstn) begin
        if (!arstn) begin
            r_txd  <= 1'b1;
            r_busy <= 1'b0;
        end else begin
            r_txd  <= w_txd_nxt;
            r_busy <= (w_state_nxt != ST_IDLE) | w_hold_valid_nxt;
        end
    end

endmodule
